// File: rtl/ee354_numlock_pkg.sv
// Shared state encoding, default timing parameters and sizing helper for the
// number-lock supervisory controller.
package ee354_numlock_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MAX_FAILS       = 3;
  localparam int DEF_LOCKOUT_CYCLES  = 20;
  localparam int DEF_OPEN_CYCLES     = 10;
  localparam int DEF_IDLE_TIMEOUT    = 50;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ee354_numlock_ctrl_if.sv
// Board/lock-side signal bundle; master is the controller, slave is the
// buttons plus lock state machine driving it.
interface ee354_numlock_ctrl_if #(
  parameter int MAX_FAILS = 3
);
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic          btn_u, btn_z;
  logic          q_I, q_Bad, unlock;
  logic          U, Z;
  logic          sm_clear, door_open, lockout;
  logic [FW-1:0] fail_count;
  logic [1:0]    state;

  modport master (
    input  btn_u, btn_z, q_I, q_Bad, unlock,
    output U, Z, sm_clear, door_open, lockout, fail_count, state
  );

  modport slave (
    output btn_u, btn_z, q_I, q_Bad, unlock,
    input  U, Z, sm_clear, door_open, lockout, fail_count, state
  );
endinterface

// File: rtl/ee354_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output follows
// the input only after DEBOUNCE_CYCLES consecutive differing samples.
module ee354_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) cnt <= '0;
      else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/ee354_numlock_ctrl.sv
// Supervisor for the number lock: debounced buttons, bad-attempt lockout,
// door-open window and abandoned-entry clearing.
module ee354_numlock_ctrl
  import ee354_numlock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MAX_FAILS       = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int OPEN_CYCLES     = DEF_OPEN_CYCLES,
  parameter int IDLE_TIMEOUT    = DEF_IDLE_TIMEOUT
) (
  input logic                 clk,
  input logic                 reset,
  ee354_numlock_ctrl_if.master bus
);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(max3(OPEN_CYCLES, LOCKOUT_CYCLES, IDLE_TIMEOUT)) + 1;
  localparam logic [FW-1:0] FAIL_MAX    = FW'(MAX_FAILS);
  localparam logic [TW-1:0] T_OPEN      = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] T_LOCK      = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] T_IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

  lock_state_e   state;
  logic [TW-1:0] timer, idle_cnt;
  logic [FW-1:0] fail_count, fail_inc;
  logic          sm_clear, bad_prev, unl_prev;
  logic          bad_rise, unl_rise, btn_any;
  logic [1:0]    deb;

  // deb[0] = U button, deb[1] = Z button
  ee354_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [1:0] (
    .clk   (clk),
    .reset (reset),
    .raw   ({bus.btn_z, bus.btn_u}),
    .deb   (deb)
  );

  assign btn_any  = |deb;
  assign bad_rise = bus.q_Bad & ~bad_prev;
  assign unl_rise = bus.unlock & ~unl_prev;
  assign fail_inc = (fail_count == FAIL_MAX) ? FAIL_MAX : fail_count + FW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARMED;
      timer      <= '0;
      idle_cnt   <= '0;
      fail_count <= '0;
      sm_clear   <= 1'b0;
      bad_prev   <= 1'b0;
      unl_prev   <= 1'b0;
    end else begin
      bad_prev <= bus.q_Bad;
      unl_prev <= bus.unlock;
      case (state)
        ARMED: begin
          sm_clear <= 1'b0;
          if (unl_rise) begin
            fail_count <= '0;
            timer      <= T_OPEN;
            idle_cnt   <= '0;
            state      <= OPEN;
          end else if (bad_rise && fail_inc == FAIL_MAX) begin
            fail_count <= fail_inc;
            timer      <= T_LOCK;
            idle_cnt   <= '0;
            sm_clear   <= 1'b1;
            state      <= LOCKOUT;
          end else begin
            if (bad_rise) fail_count <= fail_inc;
            if (bus.q_I || btn_any) idle_cnt <= '0;
            else if (idle_cnt == T_IDLE_LAST) begin
              idle_cnt <= '0;
              sm_clear <= 1'b1;
            end else idle_cnt <= idle_cnt + TW'(1);
          end
        end
        OPEN: begin
          idle_cnt <= '0;
          if (timer <= TW'(1)) begin
            timer    <= '0;
            sm_clear <= 1'b1;
            state    <= ARMED;
          end else timer <= timer - TW'(1);
        end
        LOCKOUT: begin
          idle_cnt <= '0;
          if (timer != '0) timer <= timer - TW'(1);
          // Expired timer holds at zero until every button is released.
          if (timer <= TW'(1) && !btn_any) begin
            fail_count <= '0;
            sm_clear   <= 1'b0;
            state      <= ARMED;
          end else sm_clear <= 1'b1;
        end
        default: begin
          sm_clear <= 1'b0;
          state    <= ARMED;
        end
      endcase
    end
  end

  assign bus.U          = deb[0] & (state == ARMED);
  assign bus.Z          = deb[1] & (state == ARMED);
  assign bus.sm_clear   = sm_clear;
  assign bus.door_open  = (state == OPEN);
  assign bus.lockout    = (state == LOCKOUT);
  assign bus.fail_count = fail_count;
  assign bus.state      = state;
endmodule

// File: tb/tb_ee354_numlock_ctrl.sv
// Self-checking bench for ee354_numlock_ctrl: status-sequence vector table
// plus hand-timed debounce, lockout, open-window, idle and reset sequences.
module tb_ee354_numlock_ctrl;
  localparam int MAXF = 3;
  // Observation word: {state[1:0], fail_count[1:0], U, Z, sm_clear, door_open, lockout}
  localparam logic [8:0] C_ALL = 9'h1FF, C_ST = 9'h180, C_U = 9'h010;
  localparam logic [8:0] C_Z = 9'h008, C_CLR = 9'h004;
  localparam logic [8:0] B_U = 9'h010, B_Z = 9'h008, B_CLR = 9'h004;

  typedef struct {
    string      name;
    logic [8:0] val;
    logic [8:0] care;
  } exp_t;

  typedef struct {
    string      name;
    bit         bu, bz, qi, bad, unl;
    int         n;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  vec_t tbl[$];
  logic [8:0] obs;

  ee354_numlock_ctrl_if #(.MAX_FAILS(MAXF)) bus();

  ee354_numlock_ctrl #(
    .DEBOUNCE_CYCLES(4), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(20),
    .OPEN_CYCLES(10), .IDLE_TIMEOUT(50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.state, bus.fail_count, bus.U, bus.Z, bus.sm_clear, bus.door_open, bus.lockout};

  function automatic logic [8:0] mk(int st, int fc, bit u, bit z, bit clr, bit door, bit lk);
    return {st[1:0], fc[1:0], u, z, clr, door, lk};
  endfunction

  task automatic drive(bit bu, bit bz, bit qi, bit bad, bit unl);
    bus.btn_u  = bu;
    bus.btn_z  = bz;
    bus.q_I    = qi;
    bus.q_Bad  = bad;
    bus.unlock = unl;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(string name, logic [8:0] val, logic [8:0] care);
    exp_t e;
    e.name = name;
    e.val  = val;
    e.care = care;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    if ((obs & e.care) !== (e.val & e.care)) begin
      failures++;
      $display("FAIL %s: got %b expected %b (care %b)", e.name, obs, e.val, e.care);
    end
  endtask

  task automatic step(int n, string name, logic [8:0] val, logic [8:0] care);
    expect_obs(name, val, care);
    tick(n);
    check_next();
  endtask

  task automatic add_row(string name, bit bu, bit bz, bit qi, bit bad, bit unl, int n, logic [8:0] exp);
    vec_t v;
    v.name = name; v.bu = bu; v.bz = bz; v.qi = qi; v.bad = bad; v.unl = unl;
    v.n = n; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 1, 0, 0);
    #2 reset = 1'b0;
    tick(3);
    step(0, "reset_state", mk(0, 0, 0, 0, 0, 0, 0), C_ALL);
    reset = 1'b1;
    step(1, "post_reset", mk(0, 0, 0, 0, 0, 0, 0), C_ALL);

    // Status-driven sequence: fail counting, open window, lockout, simultaneous rise.
    add_row("bad1",        0, 0, 1, 1, 0, 1,  mk(0, 1, 0, 0, 0, 0, 0));
    add_row("bad1_low",    0, 0, 1, 0, 0, 1,  mk(0, 1, 0, 0, 0, 0, 0));
    add_row("bad2",        0, 0, 1, 1, 0, 1,  mk(0, 2, 0, 0, 0, 0, 0));
    add_row("bad_hold",    0, 0, 1, 1, 0, 3,  mk(0, 2, 0, 0, 0, 0, 0));
    add_row("bad_low",     0, 0, 1, 0, 0, 1,  mk(0, 2, 0, 0, 0, 0, 0));
    add_row("unlock",      0, 0, 1, 0, 1, 1,  mk(1, 0, 0, 0, 0, 1, 0));
    add_row("open_mid",    0, 0, 1, 0, 1, 8,  mk(1, 0, 0, 0, 0, 1, 0));
    add_row("open_last",   0, 0, 1, 0, 0, 1,  mk(1, 0, 0, 0, 0, 1, 0));
    add_row("open_exit",   0, 0, 1, 0, 0, 1,  mk(0, 0, 0, 0, 1, 0, 0));
    add_row("armed_quiet", 0, 0, 1, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0));
    add_row("f1",          0, 0, 1, 1, 0, 1,  mk(0, 1, 0, 0, 0, 0, 0));
    add_row("f1_low",      0, 0, 1, 0, 0, 1,  mk(0, 1, 0, 0, 0, 0, 0));
    add_row("f2",          0, 0, 1, 1, 0, 1,  mk(0, 2, 0, 0, 0, 0, 0));
    add_row("f2_low",      0, 0, 1, 0, 0, 1,  mk(0, 2, 0, 0, 0, 0, 0));
    add_row("f3_lockout",  0, 0, 1, 1, 0, 1,  mk(2, 3, 0, 0, 1, 0, 1));
    add_row("lockout_end", 0, 0, 1, 0, 0, 19, mk(2, 3, 0, 0, 1, 0, 1));
    add_row("lockout_exit",0, 0, 1, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0));
    add_row("post_lk_bad", 0, 0, 1, 1, 0, 1,  mk(0, 1, 0, 0, 0, 0, 0));
    add_row("post_lk_low", 0, 0, 1, 0, 0, 1,  mk(0, 1, 0, 0, 0, 0, 0));
    add_row("simul_rise",  0, 0, 1, 1, 1, 1,  mk(1, 0, 0, 0, 0, 1, 0));
    add_row("simul_exit",  0, 0, 1, 0, 0, 10, mk(0, 0, 0, 0, 1, 0, 0));
    add_row("simul_armed", 0, 0, 1, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].bu, tbl[i].bz, tbl[i].qi, tbl[i].bad, tbl[i].unl);
      expect_obs(tbl[i].name, tbl[i].exp, C_ALL);
      tick(tbl[i].n);
      check_next();
    end

    // Glitch of two samples must never reach U.
    drive(1, 0, 1, 0, 0);
    for (int t = 0; t < 2; t++) step(1, "glitch_u", '0, C_U);
    drive(0, 0, 1, 0, 0);
    for (int t = 0; t < 8; t++) step(1, "glitch_u", '0, C_U);

    // Held press: U rises on the 6th edge (k+5), falls 5 edges after release.
    drive(1, 0, 1, 0, 0);
    step(5, "u_rise_early", '0, C_U);
    step(1, "u_rise", B_U, C_U);
    step(4, "u_held", B_U, C_U);
    drive(0, 0, 1, 0, 0);
    step(5, "u_fall_early", B_U, C_U);
    step(1, "u_fall", '0, C_U);

    // Lockout with btn_u held through expiry.
    drive(1, 0, 1, 0, 0);
    step(6, "lk_u_on", B_U, C_U);
    drive(1, 0, 1, 1, 0); step(1, "lk_bad1", mk(0, 1, 1, 0, 0, 0, 0), C_ALL);
    drive(1, 0, 1, 0, 0); tick(1);
    drive(1, 0, 1, 1, 0); step(1, "lk_bad2", mk(0, 2, 1, 0, 0, 0, 0), C_ALL);
    drive(1, 0, 1, 0, 0); tick(1);
    drive(1, 0, 1, 1, 0); step(1, "lk_enter", mk(2, 3, 0, 0, 1, 0, 1), C_ALL);
    drive(1, 0, 1, 0, 0);
    for (int t = 0; t < 19; t++) step(1, "lk_window", mk(2, 3, 0, 0, 1, 0, 1), C_ALL);
    step(1, "lk_btn_held", mk(2, 3, 0, 0, 1, 0, 1), C_ALL);
    step(5, "lk_btn_held2", mk(2, 3, 0, 0, 1, 0, 1), C_ALL);
    drive(0, 0, 1, 0, 0);
    step(6, "lk_deb_falling", mk(2, 3, 0, 0, 1, 0, 1), C_ALL);
    step(1, "lk_release_exit", mk(0, 0, 0, 0, 0, 0, 0), C_ALL);

    // Success with fail_count=2 and btn_z held: masked through the window.
    drive(0, 1, 1, 0, 0);
    step(6, "z_on", B_Z, C_Z);
    drive(0, 1, 1, 1, 0); step(1, "s_bad1", mk(0, 1, 0, 1, 0, 0, 0), C_ALL);
    drive(0, 1, 1, 0, 0); tick(1);
    drive(0, 1, 1, 1, 0); step(1, "s_bad2", mk(0, 2, 0, 1, 0, 0, 0), C_ALL);
    drive(0, 1, 1, 0, 0); tick(1);
    drive(0, 1, 1, 0, 1); step(1, "s_unlock", mk(1, 0, 0, 0, 0, 1, 0), C_ALL);
    drive(0, 1, 1, 0, 0);
    for (int t = 0; t < 9; t++) step(1, "s_open", mk(1, 0, 0, 0, 0, 1, 0), C_ALL);
    step(1, "s_exit", mk(0, 0, 0, 1, 1, 0, 0), C_ALL);
    step(1, "s_armed", mk(0, 0, 0, 1, 0, 0, 0), C_ALL);
    drive(0, 0, 1, 0, 0);
    step(6, "z_off", '0, C_Z);

    // Idle timeout, then a press just before the next timeout restarts the count.
    drive(0, 0, 0, 0, 0);
    for (int t = 1; t <= 49; t++) step(1, "idle_wait", '0, C_CLR);
    step(1, "idle_clear", B_CLR, C_ST | C_CLR);
    for (int t = 1; t <= 105; t++) begin
      step(1, "idle_restart", '0, C_CLR);
      if (t == 43) drive(1, 0, 0, 0, 0);
      if (t == 50) drive(0, 0, 0, 0, 0);
    end
    step(1, "idle_clear2", B_CLR, C_ST | C_CLR);
    step(1, "idle_pulse_end", '0, C_CLR);
    drive(0, 0, 1, 0, 0);

    // Reset asserted in the middle of a lockout.
    drive(0, 0, 1, 1, 0); tick(1);
    drive(0, 0, 1, 0, 0); tick(1);
    drive(0, 0, 1, 1, 0); tick(1);
    drive(0, 0, 1, 0, 0); tick(1);
    drive(0, 0, 1, 1, 0); step(1, "rst_pre_lockout", mk(2, 3, 0, 0, 1, 0, 1), C_ALL);
    drive(0, 0, 1, 0, 0);
    tick(5);
    reset = 1'b0;
    step(0, "rst_async", mk(0, 0, 0, 0, 0, 0, 0), C_ALL);
    step(3, "rst_held", mk(0, 0, 0, 0, 0, 0, 0), C_ALL);
    reset = 1'b1;
    step(1, "rst_release", mk(0, 0, 0, 0, 0, 0, 0), C_ALL);
    drive(0, 0, 1, 1, 0);
    step(1, "rst_then_bad", mk(0, 1, 0, 0, 0, 0, 0), C_ALL);
    drive(0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ee354_numlock_ctrl.md
# ee354_numlock_ctrl

Supervisory controller for the `ee354_numlock_sm` number lock.
- Debounces the raw U/Z push-buttons and forwards clean levels to the lock.
- Counts bad-combination attempts and enforces a lockout after `MAX_FAILS` failures.
- Times the door-open window after `Unlock`.
- Clears abandoned partial entries.

Sits between the board buttons and the lock state machine at the top level. `sm_clear` is ORed into the lock's active-high reset.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a button change (≥2).
- `MAX_FAILS`, 3: bad attempts that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 20: lockout duration in clocks.
- `OPEN_CYCLES`, 10: door-open window in clocks.
- `IDLE_TIMEOUT`, 50: clocks of no button activity outside `q_I` before the entry is cleared.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_u`, `btn_z`  in  1  raw asynchronous push-buttons.
- `q_I`, `q_Bad`, `unlock`  in  1  status from the lock state machine (synchronous to `clk`).
- `U`, `Z`  out  1  debounced, masked button levels to the lock.
- `sm_clear`  out  1  registered, active-high clear request to the lock.
- `door_open`  out  1  high during the open window.
- `lockout`  out  1  high during lockout.
- `fail_count`  out  `$clog2(MAX_FAILS+1)`  bad attempts since the last success or lockout.
- `state`  out  2  FSM state: ARMED=0, OPEN=1, LOCKOUT=2.

## Operation
- **Reset.** While `reset`=0, every register clears. State=ARMED; all outputs 0; synchronizers, debounce counters, timers and edge-detect flops 0. Reset asserted mid-operation aborts immediately.
- **Button path** (per button):
  - 2-flop synchronizer, then debounce.
  - The counter increments while the synchronized value differs from the debounced value.
  - The debounced value takes the new level when the count reaches `DEBOUNCE_CYCLES`.
  - The counter clears whenever the two agree.
  - `U` = deb_u & (state==ARMED); `Z` likewise.
- **Edge detect.** `q_Bad` and `unlock` each have a registered previous value; a rise is cur & ~prev.
- **ARMED:**
  - `unlock` rise: `fail_count`←0, timer←`OPEN_CYCLES`, →OPEN.
  - Else `q_Bad` rise:
    - `fail_count`+1.
    - If the new value == `MAX_FAILS`: timer←`LOCKOUT_CYCLES`, →LOCKOUT.
    - `fail_count` saturates at `MAX_FAILS`.
  - `unlock` rise and `q_Bad` rise in the same cycle: `unlock` wins; `fail_count` is unchanged except for the clear.
  - Idle timer:
    - Counts while `q_I`=0 and both debounced buttons are 0.
    - Clears on any debounced button high, or when `q_I`=1.
    - At `IDLE_TIMEOUT`: `sm_clear` pulses 1 cycle, timer clears, state stays ARMED.
- **OPEN:**
  - `door_open`=1; `U`/`Z` masked.
  - Timer decrements each cycle.
  - When the timer reaches 0: `sm_clear` pulses 1 cycle, →ARMED.
- **LOCKOUT:**
  - `lockout`=1 and `sm_clear`=1 continuously; `U`/`Z` masked.
  - Timer decrements each cycle.
  - At 0, if both debounced buttons are 0: `fail_count`←0, →ARMED.
  - If a button is still held at 0: remain in LOCKOUT (timer holds at 0) until release.
- The idle timer is held clear outside ARMED.

## Timing
- All outputs are registered, or simple AND of registers with state decode. No input→output combinational path.
- **Button latency.** A clean raw edge sampled at edge k appears on `U`/`Z` after edge k+1+`DEBOUNCE_CYCLES`.
- **Glitch rejection.** A pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles is rejected.
- **Status latency.** `q_Bad`/`unlock` rise sampled at edge k: state/`fail_count` update at edge k+1.
- **OPEN:** `door_open` is high for exactly `OPEN_CYCLES` cycles. The `sm_clear` pulse coincides with the first ARMED cycle.
- **LOCKOUT:** lasts `LOCKOUT_CYCLES` cycles minimum. `lockout` and `sm_clear` deassert together.

## Structure
- Package `ee354_numlock_pkg`:
  - State encoding constants ARMED/OPEN/LOCKOUT.
  - Default parameter values.
- Sub-module `ee354_debounce` (synchronizer + debounce counter, parameter `DEBOUNCE_CYCLES`), instantiated twice.
- FSM, timers, fail counter and edge detectors live in the top.
- Timer width = `$clog2` of the max of `OPEN_CYCLES`, `LOCKOUT_CYCLES`, `IDLE_TIMEOUT`, plus 1.

## Test plan
- **Reset:** hold `reset`=0 mid-LOCKOUT, release → state=0, `lockout`=0, `fail_count`=0, `sm_clear`=0 on the first edge after release.
- **Debounce:** `btn_u` high 2 cycles then low → `U` never asserts. `btn_u` held 10 cycles → `U` rises 5 edges after the first sample, falls 5 edges after release.
- **Failures:** three `q_Bad` rises → `fail_count` 1,2,3.
  - On the 3rd: `lockout`=`sm_clear`=1 for 20 cycles, `U` stays 0 with `btn_u` held.
  - Exit only after `btn_u` release; `fail_count`→0.
- **Success:** `unlock` rise with `fail_count`=2 → `fail_count`=0, `door_open` high exactly 10 cycles, then one-cycle `sm_clear`. Buttons masked throughout.
- **Idle:** `q_I`=0, no buttons for 50 cycles → single `sm_clear` pulse, state stays ARMED. A button press at cycle 49 restarts the count.
- **Simultaneous:** `unlock` and `q_Bad` rise in the same cycle → OPEN, `fail_count`=0, no lockout.
